awm_panel: RTL and testbench
============================

# awm_panel

Front-panel interface for the washing-machine controller. Synchronises and debounces the raw START and PAUSE push-buttons and turns them into the controller's `start` and `pause` command inputs. Consumes the controller's `stage`/`done` status to drive the door lock, stage LEDs, end-of-cycle buzzer and a sticky stage-error flag. Sits between the board pins and the controller FSM, on the same clock.

## Interface
- `DEB_CYCLES`, default 4: consecutive stable synchronised samples required to accept a button level; legal 1..255.
- `UNLOCK_DLY`, default 8: cycles spent in PAUSED before `door_lock` releases; legal 1..255.
- `BUZZ_CYCLES`, default 16: buzzer on-time at end of cycle; legal 1..255.
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_start`  in  1  raw START button, asynchronous, high = pressed.
- `btn_pause`  in  1  raw PAUSE button, asynchronous, high = pressed.
- `stage`  in  3  controller stage: 3'b000 fill, 001 wash, 010 rinse, 011 spin, 111 idle/paused; 100–110 illegal.
- `done`  in  1  controller end-of-cycle flag.
- `start`  out  1  command to controller; level.
- `pause`  out  1  command to controller; level.
- `door_lock`  out  1  door solenoid, high = locked.
- `led`  out  4  one-hot stage LEDs; bit n lit when `stage`==n (n = 0..3).
- `buzzer`  out  1  end-of-cycle buzzer.
- `err`  out  1  sticky illegal-stage flag.

## Operation
- Each button: 2-flop synchroniser, then an 8-bit stability counter. The debounced level updates only after `DEB_CYCLES` consecutive equal samples. A press event is a one-cycle pulse on the debounced rising edge. Release events are not used.
- FSM states: IDLE, RUNNING, PAUSED, FINISH.
- IDLE: `start`=0, `pause`=0, `door_lock`=0. A start event moves to RUNNING. Pause events are ignored.
- RUNNING: `start`=1, `pause`=0, `door_lock`=1.
  - `done`=1 moves to FINISH.
  - Otherwise a pause event moves to PAUSED.
  - Start events are ignored.
- PAUSED: `start`=1, `pause`=1.
  - Unlock counter clears on entry. `door_lock` stays 1 until the counter reaches `UNLOCK_DLY`, then 0.
  - A pause event returns to RUNNING, sets `door_lock`=1 on the same edge, and clears the counter.
  - Start events are ignored. `done` is ignored.
- FINISH: `start`=0, `pause`=0, `door_lock`=0. Buzzer counter runs for `BUZZ_CYCLES` cycles, then the FSM goes to IDLE. All button events are ignored.
- Simultaneous events:
  - `done` beats a pause event in RUNNING.
  - A start and pause event in the same cycle in IDLE: start is taken.
- `led`: registered decode of `stage`. It is 4'b0000 for 111 and for illegal values.
- `err`: set when `stage` is in 100..110 in any state. Cleared only by reset.
- Counters saturate and never wrap.

## Timing
- Reset (async assert, sync-release use): state IDLE, `start`=0, `pause`=0, `door_lock`=0, `led`=0, `buzzer`=0, `err`=0, synchroniser, debounced levels and all counters 0.
- Reset mid-cycle (any state) returns to IDLE immediately and unlocks the door. No command persists.
- Button latency, raw rising before edge 0:
  - synchronised at edge 2;
  - press pulse high after edge 2+`DEB_CYCLES`;
  - command outputs change at edge 3+`DEB_CYCLES` (7 with defaults).
- A glitch shorter than `DEB_CYCLES` synchronised cycles produces no event.
- `done`/`stage` are sampled directly (synchronous to `clk`). FSM outputs change on the edge after `done` is sampled high. `led`/`err` lag `stage` by one edge.
- All outputs are registered.

## Configuration
- `AWM_BUZZER_EN` defined: buzzer counter present; `buzzer`=1 throughout FINISH (`BUZZ_CYCLES` cycles); FINISH lasts `BUZZ_CYCLES` cycles.
- `AWM_BUZZER_EN` undefined: no buzzer counter; `buzzer` tied 0; FINISH lasts exactly one cycle, then IDLE.

## Test plan
- Defaults, buzzer enabled: hold `btn_start` 10 cycles from IDLE -> `start`=1 and `door_lock`=1 at edge 7; single transition only.
- 3-cycle pulse on `btn_pause` while RUNNING -> no change to `pause`; 6-cycle hold -> `pause`=1 at edge 7. `door_lock` drops exactly 8 cycles later. A second press -> `pause`=0, `door_lock`=1.
- Drive `done`=1 in the same cycle a pause event fires -> FINISH: `start`=0, `pause`=0, `door_lock`=0, `buzzer`=1 for 16 cycles, then IDLE.
- Sweep `stage` 000..011 then 111 -> `led` 0001, 0010, 0100, 1000, 0000, each one edge late. `stage`=101 for one cycle -> `err`=1, held until reset.
- Assert `reset` low while PAUSED and locked -> all outputs 0 immediately, state IDLE. A start press after release restarts normally.
- Compile without `AWM_BUZZER_EN` -> `buzzer` stays 0; FINISH->IDLE after one cycle.

Source files
------------

// File: rtl/awm_panel.sv
// awm_panel: front-panel button debounce, door lock, stage LEDs and error flag.
// Define AWM_BUZZER_EN to build the timed end-of-cycle buzzer.
module awm_panel #(
  parameter int DEB_CYCLES  = 4,
  parameter int UNLOCK_DLY  = 8,
  parameter int BUZZ_CYCLES = 16
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_btn_start,
  input  logic       i_btn_pause,
  input  logic [2:0] i_stage,
  input  logic       i_done,
  output logic       o_start,
  output logic       o_pause,
  output logic       o_door_lock,
  output logic [3:0] o_led,
  output logic       o_buzzer,
  output logic       o_err
);

  localparam logic [7:0] DEB_M1   = 8'(DEB_CYCLES - 1);
  localparam logic [7:0] UNLOCK_L = 8'(UNLOCK_DLY);
  localparam logic [7:0] BUZZ_M1  = 8'(BUZZ_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  // bit 0 = START, bit 1 = PAUSE
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] r_deb;
  logic [1:0] r_deb_q;
  logic [1:0] r_press;
  logic [7:0] r_cnt [2];

  logic [1:0] r_state;
  logic [7:0] r_ucnt;
  logic       r_start;
  logic       r_pause;
  logic       r_lock;
  logic [3:0] r_led;
  logic       r_err;

  logic       w_start_ev;
  logic       w_pause_ev;
  logic [1:0] w_nstate;
  logic [7:0] w_ucnt;
  logic       w_lock;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_q <= '0;
      r_press <= '0;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= {i_btn_pause, i_btn_start};
      r_sync2 <= r_sync1;
      r_deb_q <= r_deb;
      r_press <= r_deb & ~r_deb_q;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] >= DEB_M1) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
    end
  end

  assign w_start_ev = r_press[0];
  assign w_pause_ev = r_press[1];

`ifdef AWM_BUZZER_EN
  logic [7:0] r_bcnt;
  logic [7:0] w_bcnt;
  logic       r_buzz;
`else
  logic w_unused_buzz;
  assign w_unused_buzz = ^BUZZ_M1;
`endif

  always_comb begin
    w_nstate = r_state;
    w_ucnt   = r_ucnt;
`ifdef AWM_BUZZER_EN
    w_bcnt   = r_bcnt;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_start_ev) w_nstate = S_RUN;
      end
      S_RUN: begin
        if (i_done) begin
          w_nstate = S_FIN;
`ifdef AWM_BUZZER_EN
          w_bcnt   = '0;
`endif
        end else if (w_pause_ev) begin
          w_nstate = S_PAUSE;
          w_ucnt   = '0;
        end
      end
      S_PAUSE: begin
        if (w_pause_ev) begin
          w_nstate = S_RUN;
          w_ucnt   = '0;
        end else if (r_ucnt < UNLOCK_L) begin
          w_ucnt = r_ucnt + 8'd1;
        end
      end
      S_FIN: begin
`ifdef AWM_BUZZER_EN
        if (r_bcnt >= BUZZ_M1) begin
          w_nstate = S_IDLE;
          w_bcnt   = '0;
        end else begin
          w_bcnt = r_bcnt + 8'd1;
        end
`else
        w_nstate = S_IDLE;
`endif
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  // lock releases on the edge the paused counter reaches the delay
  assign w_lock = (w_nstate == S_RUN) |
                  ((w_nstate == S_PAUSE) & (w_ucnt < UNLOCK_L));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_ucnt  <= '0;
      r_start <= 1'b0;
      r_pause <= 1'b0;
      r_lock  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_ucnt  <= w_ucnt;
      r_start <= (w_nstate == S_RUN) | (w_nstate == S_PAUSE);
      r_pause <= (w_nstate == S_PAUSE);
      r_lock  <= w_lock;
    end
  end

`ifdef AWM_BUZZER_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_bcnt <= '0;
      r_buzz <= 1'b0;
    end else begin
      r_bcnt <= w_bcnt;
      r_buzz <= (w_nstate == S_FIN);
    end
  end
  assign o_buzzer = r_buzz;
`else
  assign o_buzzer = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_led <= '0;
      r_err <= 1'b0;
    end else begin
      unique case (1'b1)
        (i_stage == 3'd0): r_led <= 4'b0001;
        (i_stage == 3'd1): r_led <= 4'b0010;
        (i_stage == 3'd2): r_led <= 4'b0100;
        (i_stage == 3'd3): r_led <= 4'b1000;
        default:           r_led <= 4'b0000;
      endcase
      r_err <= r_err | (i_stage[2] & ~(&i_stage));
    end
  end

  assign o_start     = r_start;
  assign o_pause     = r_pause;
  assign o_door_lock = r_lock;
  assign o_led       = r_led;
  assign o_err       = r_err;

endmodule

// File: tb/tb_awm_panel.sv
// tb_awm_panel: table vectors, hand-timed sequences and a randomized
// run against an event-level model of the panel.
module tb_awm_panel;

  localparam int DEB    = 4;
  localparam int UNLOCK = 8;
  localparam int N      = 1500;
`ifdef AWM_BUZZER_EN
  localparam int   FIN_LEN = 16;
  localparam logic BUZZ_ON = 1'b1;
`else
  localparam int   FIN_LEN = 1;
  localparam logic BUZZ_ON = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       btn_s;
  logic       btn_p;
  logic [2:0] stage;
  logic       done;
  logic       o_start;
  logic       o_pause;
  logic       o_door_lock;
  logic [3:0] o_led;
  logic       o_buzzer;
  logic       o_err;

  awm_panel dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_btn_start (btn_s),
    .i_btn_pause (btn_p),
    .i_stage     (stage),
    .i_done      (done),
    .o_start     (o_start),
    .o_pause     (o_pause),
    .o_door_lock (o_door_lock),
    .o_led       (o_led),
    .o_buzzer    (o_buzzer),
    .o_err       (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [2:0] stage;
    logic [3:0] led;
    logic       err;
  } led_vec_t;

  led_vec_t tbl [10];

  bit         rs  [N];
  bit         rp  [N];
  bit         dn  [N];
  logic [2:0] st  [N];
  bit         evs [N];
  bit         evp [N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkb(input string nm, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [11:0] got,
                      input logic [11:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [3:0] led_of(input logic [2:0] s);
    if (s <= 3'd3) return 4'(1 << s);
    return 4'b0000;
  endfunction

  task automatic chk_all_zero(input string nm);
    chkv(nm, 12'({o_start, o_pause, o_door_lock, o_buzzer, o_led, o_err}),
         12'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // drive START for 10 edges from IDLE; command must appear at edge 7
  task automatic start_press(input string nm);
    btn_s = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 6) chkb({nm, "_e6"}, o_start, 1'b0);
      if (k == 7) begin
        chkb({nm, "_e7"}, o_start, 1'b1);
        chkb({nm, "_lock"}, o_door_lock, 1'b1);
      end
    end
    btn_s = 1'b0;
  endtask

  // 6-edge PAUSE hold; returns just after the edge the event acts on
  task automatic pause_press();
    btn_p = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 5) btn_p = 1'b0;
    end
  endtask

  int   m_state;
  int   pc;
  int   fa;
  logic e_start, e_pause, e_lock, e_buzz;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    tbl[0] = '{3'b000, 4'b0001, 1'b0};
    tbl[1] = '{3'b001, 4'b0010, 1'b0};
    tbl[2] = '{3'b010, 4'b0100, 1'b0};
    tbl[3] = '{3'b011, 4'b1000, 1'b0};
    tbl[4] = '{3'b111, 4'b0000, 1'b0};
    tbl[5] = '{3'b101, 4'b0000, 1'b1};
    tbl[6] = '{3'b000, 4'b0001, 1'b1};
    tbl[7] = '{3'b100, 4'b0000, 1'b1};
    tbl[8] = '{3'b110, 4'b0000, 1'b1};
    tbl[9] = '{3'b111, 4'b0000, 1'b1};

    rst_n = 1'b0;
    btn_s = 1'b0;
    btn_p = 1'b0;
    stage = 3'b111;
    done  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    begin
      logic [3:0] prev;
      prev = 4'b0000;
      for (int i = 0; i < 10; i++) begin
        stage = tbl[i].stage;
        #1;
        chkv("led_lag", 12'(o_led), 12'(prev));
        tick();
        chkv("led_tbl", 12'(o_led), 12'(tbl[i].led));
        chkb("err_tbl", o_err, tbl[i].err);
        prev = tbl[i].led;
      end
    end
    repeat (3) tick();
    chkb("err_sticky", o_err, 1'b1);
    rst_n = 1'b0;
    #2;
    chkb("err_async_clr", o_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    start_press("start");
    repeat (12) tick();
    chkb("start_single", o_start, 1'b1);
    chkb("start_no_pause", o_pause, 1'b0);

    btn_p = 1'b1;
    repeat (3) tick();
    btn_p = 1'b0;
    repeat (12) tick();
    chkb("pause_glitch", o_pause, 1'b0);

    btn_p = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 5) btn_p = 1'b0;
      if (k == 6) chkb("pause_e6", o_pause, 1'b0);
      if (k == 7) begin
        chkb("pause_e7", o_pause, 1'b1);
        chkb("pause_lock", o_door_lock, 1'b1);
      end
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 7) chkb("unlock_e7", o_door_lock, 1'b1);
      if (k == 8) chkb("unlock_e8", o_door_lock, 1'b0);
    end
    chkb("paused_start", o_start, 1'b1);
    repeat (4) tick();
    pause_press();
    chkv("resume", 12'({o_start, o_pause, o_door_lock}), 12'(3'b101));

    // done and pause event land on the same edge (j==0)
    for (int j = -7; j <= FIN_LEN + 10; j++) begin
      if (j == -7) btn_p = 1'b1;
      if (j == -1) btn_p = 1'b0;
      if (j == FIN_LEN - 7) btn_s = 1'b1;
      if (j == FIN_LEN - 1) btn_s = 1'b0;
      done = (j == 0);
      tick();
      if (j == 0) begin
        chkv("done_beats_pause",
             12'({o_start, o_pause, o_door_lock}), 12'd0);
      end
      if (j >= 0 && j < FIN_LEN) chkb("buzz_on", o_buzzer, BUZZ_ON);
      if (j >= FIN_LEN) begin
        chkb("buzz_off", o_buzzer, 1'b0);
        chkb("fin_ignores_start", o_start, 1'b0);
      end
    end
    done = 1'b0;
    repeat (6) tick();

    start_press("restart");
    repeat (4) tick();
    pause_press();
    repeat (2) tick();
    chkv("pre_reset_paused", 12'({o_pause, o_door_lock}), 12'(2'b11));
    rst_n = 1'b0;
    #2;
    chk_all_zero("reset_mid_pause");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start_press("post_reset");
    repeat (8) tick();

    for (int c = 0; c < N; c++) begin
      rs[c]  = 1'b0;
      rp[c]  = 1'b0;
      evs[c] = 1'b0;
      evp[c] = 1'b0;
      dn[c]  = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 4))
        0: st[c] = 3'b000;
        1: st[c] = 3'b001;
        2: st[c] = 3'b010;
        3: st[c] = 3'b011;
        default: st[c] = 3'b111;
      endcase
    end
    begin
      int c;
      int sel;
      int len;
      int gap;
      c = 0;
      while (c < N) begin
        sel = $urandom_range(0, 2);
        len = $urandom_range(1, 8);
        for (int k = 0; k < len && c < N; k++) begin
          rs[c] = (sel != 1);
          rp[c] = (sel != 0);
          c++;
        end
        gap = $urandom_range(DEB + 1, DEB + 12);
        c += gap;
      end
    end
    // a high run of at least DEB samples yields one press, 3+DEB edges later
    for (int c = 0; c < N; c++) begin
      if (rs[c] && (c == 0 || !rs[c-1])) begin
        int len;
        len = 0;
        while (c + len < N && rs[c+len]) len++;
        if (len >= DEB && c + 3 + DEB < N) evs[c+3+DEB] = 1'b1;
      end
      if (rp[c] && (c == 0 || !rp[c-1])) begin
        int len;
        len = 0;
        while (c + len < N && rp[c+len]) len++;
        if (len >= DEB && c + 3 + DEB < N) evp[c+3+DEB] = 1'b1;
      end
    end

    do_reset();
    m_state = 0;
    pc      = 0;
    fa      = 0;
    for (int n = 0; n < N; n++) begin
      btn_s = rs[n];
      btn_p = rp[n];
      done  = dn[n];
      stage = st[n];
      tick();
      case (m_state)
        0: if (evs[n]) m_state = 1;
        1: begin
          if (dn[n]) begin
            m_state = 3;
            fa      = 1;
          end else if (evp[n]) begin
            m_state = 2;
            pc      = 0;
          end
        end
        2: begin
          if (evp[n]) m_state = 1;
          else if (pc < 255) pc++;
        end
        default: begin
          if (fa >= FIN_LEN) m_state = 0;
          else fa++;
        end
      endcase
      e_start = (m_state == 1) || (m_state == 2);
      e_pause = (m_state == 2);
      e_lock  = (m_state == 1) || (m_state == 2 && pc < UNLOCK);
      e_buzz  = BUZZ_ON && (m_state == 3);
      chkv("rand",
           12'({o_start, o_pause, o_door_lock, o_buzzer, o_led, o_err}),
           12'({e_start, e_pause, e_lock, e_buzz, led_of(st[n]), 1'b0}));
    end

    btn_s = 1'b0;
    btn_p = 1'b0;
    done  = 1'b0;
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
